// File: rtl/instr_control_if.sv
// instr_control_if: instruction handshake and decoded control bundle.
//   master : upstream/issuer side (drives instruction, instr_valid)
//   slave  : instr_control side (drives ready, register-file and ALU controls)
interface instr_control_if;
    logic [31:0] instruction;   // OP[31:24] DEST/IMM[23:16] SRC1[15:8] SRC2/IMM[7:0]
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  readreg1;
    logic [2:0]  readreg2;
    logic [2:0]  writereg;
    logic        writeenable;
    logic [2:0]  aluop;
    logic [7:0]  immediate;
    logic        imm_sel;
    logic        neg_sel;
    logic        done;
    logic        illegal;

    modport master (
        output instruction, instr_valid,
        input  instr_ready, readreg1, readreg2, writereg, writeenable,
               aluop, immediate, imm_sel, neg_sel, done, illegal
    );

    modport slave (
        input  instruction, instr_valid,
        output instr_ready, readreg1, readreg2, writereg, writeenable,
               aluop, immediate, imm_sel, neg_sel, done, illegal
    );
endinterface

// File: rtl/instr_control.sv
// instr_control: four-state instruction sequencer (IDLE/DECODE/EXEC/WB).
// Ports:
//   clk    : system clock, rising-edge active
//   rst_n  : asynchronous active-low reset
//   bus    : instr_control_if.slave (handshake in, decoded controls out)
// Parameter ALU_LAT (1..15): cycles spent in EXEC waiting for the ALU.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | ready for an instruction; decoded outputs hold last values
// ST_DECODE | decoded controls valid; illegal opcode returns to IDLE here
// ST_EXEC   | down-counter from ALU_LAT, leaves on terminal count 1
// ST_WB     | writeenable (ops 0-5) and done pulse for one cycle
module instr_control #(
    parameter int unsigned ALU_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    instr_control_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_EXEC, ST_WB} state_t;

    state_t      state_q;
    logic [31:0] instr_q;
    logic [3:0]  cnt_q;
    logic        instr_ready_q;
    logic [2:0]  readreg1_q;
    logic [2:0]  readreg2_q;
    logic [2:0]  writereg_q;
    logic        writeenable_q;
    logic [2:0]  aluop_q;
    logic [7:0]  immediate_q;
    logic        imm_sel_q;
    logic        neg_sel_q;
    logic        done_q;
    logic        illegal_q;

    logic [7:0]  op_in;
    logic [7:0]  op_q;
    logic [2:0]  aluop_d;
    logic [7:0]  immediate_d;
    logic        imm_sel_d;
    logic        neg_sel_d;
    logic        legal_d;

    assign op_in = bus.instruction[31:24];
    assign op_q  = instr_q[31:24];

    // Decode the incoming word so the registered controls are already
    // valid during the DECODE cycle that follows acceptance.
    always_comb begin
        aluop_d     = 3'd0;
        immediate_d = 8'd0;
        imm_sel_d   = 1'b0;
        neg_sel_d   = 1'b0;
        legal_d     = 1'b1;
        case (op_in)
            8'd0: begin
                imm_sel_d   = 1'b1;
                immediate_d = bus.instruction[7:0];
            end
            8'd1: ;
            8'd2: aluop_d = 3'd1;
            8'd3: begin
                aluop_d   = 3'd1;
                neg_sel_d = 1'b1;
            end
            8'd4: aluop_d = 3'd2;
            8'd5: aluop_d = 3'd3;
            8'd6: aluop_d = 3'd1;
            8'd7: begin
                aluop_d   = 3'd1;
                neg_sel_d = 1'b1;
            end
            default: legal_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            instr_q       <= '0;
            cnt_q         <= '0;
            instr_ready_q <= 1'b1;
            readreg1_q    <= '0;
            readreg2_q    <= '0;
            writereg_q    <= '0;
            writeenable_q <= 1'b0;
            aluop_q       <= '0;
            immediate_q   <= '0;
            imm_sel_q     <= 1'b0;
            neg_sel_q     <= 1'b0;
            done_q        <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            writeenable_q <= 1'b0;
            done_q        <= 1'b0;
            illegal_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.instr_valid) begin
                        instr_q       <= bus.instruction;
                        readreg1_q    <= bus.instruction[10:8];
                        readreg2_q    <= bus.instruction[2:0];
                        writereg_q    <= bus.instruction[18:16];
                        aluop_q       <= aluop_d;
                        immediate_q   <= immediate_d;
                        imm_sel_q     <= imm_sel_d;
                        neg_sel_q     <= neg_sel_d;
                        illegal_q     <= ~legal_d;
                        instr_ready_q <= 1'b0;
                        state_q       <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (op_q > 8'd7) begin
                        instr_ready_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else begin
                        cnt_q   <= 4'(ALU_LAT);
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt_q == 4'd1) begin
                        cnt_q         <= '0;
                        writeenable_q <= (op_q <= 8'd5);
                        done_q        <= 1'b1;
                        state_q       <= ST_WB;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_WB: begin
                    instr_ready_q <= 1'b1;
                    state_q       <= ST_IDLE;
                end
                default: begin
                    instr_ready_q <= 1'b1;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

    // Fields carried in the instruction word that no control depends on.
    logic unused_bits;
    assign unused_bits = ^{bus.instruction[23:19], bus.instruction[15:11], instr_q[23:0]};

    assign bus.instr_ready = instr_ready_q;
    assign bus.readreg1    = readreg1_q;
    assign bus.readreg2    = readreg2_q;
    assign bus.writereg    = writereg_q;
    assign bus.writeenable = writeenable_q;
    assign bus.aluop       = aluop_q;
    assign bus.immediate   = immediate_q;
    assign bus.imm_sel     = imm_sel_q;
    assign bus.neg_sel     = neg_sel_q;
    assign bus.done        = done_q;
    assign bus.illegal     = illegal_q;
endmodule

// File: tb/tb_instr_control.sv
module tb_instr_control;
    localparam int LAT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    instr_control_if if0();

    instr_control #(.ALU_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    int n_vec = 0;
    int n_err = 0;
    bit check_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    typedef struct packed {
        logic [2:0] rr1;
        logic [2:0] rr2;
        logic [2:0] wr;
        logic [2:0] aluop;
        logic [7:0] imm;
        logic       isel;
        logic       nsel;
    } fields_t;

    function automatic fields_t decode_ref(input logic [31:0] ins);
        fields_t f;
        int alu_tab[8] = '{0, 0, 1, 1, 2, 3, 1, 1};
        logic [7:0] op;
        op     = ins[31:24];
        f.rr1  = ins[10:8];
        f.rr2  = ins[2:0];
        f.wr   = ins[18:16];
        f.aluop = 3'(alu_tab[op[2:0]]);
        f.isel = (op == 8'd0);
        f.imm  = (op == 8'd0) ? ins[7:0] : 8'd0;
        f.nsel = (op == 8'd3) || (op == 8'd7);
        return f;
    endfunction

    // Each instruction occupies the periods from its acceptance edge until
    // end_e: 1 (illegal) or 2+LAT (legal) periods, WB being the last busy one.
    int      cyc = 0;
    int      acc = 0;
    int      end_e = 0;
    bit      in_flight = 0;
    bit      m_legal = 0;
    bit      known = 1;
    logic [31:0] m_instr = '0;
    fields_t m_f = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight = 0;
            known     = 1;
            m_f       = '0;
        end else begin
            cyc = cyc + 1;
            if (!in_flight) begin
                if (if0.instr_valid === 1'b1) begin
                    in_flight = 1;
                    acc       = cyc;
                    m_instr   = if0.instruction;
                    m_legal   = (m_instr[31:24] <= 8'd7);
                    end_e     = m_legal ? cyc + LAT + 2 : cyc + 1;
                    if (m_legal) begin
                        m_f   = decode_ref(m_instr);
                        known = 1;
                    end else begin
                        known = 0;
                    end
                end
            end else if (cyc == end_e) begin
                in_flight = 0;
            end
        end
    end

    always @(negedge clk) begin
        bit dn;
        bit we;
        bit il;
        if (check_en) begin
            dn = in_flight && m_legal && (cyc == acc + LAT + 1);
            we = dn && (m_instr[31:24] <= 8'd5);
            il = in_flight && !m_legal && (cyc == acc);
            chk("m_ready",   32'(if0.instr_ready), 32'(!in_flight));
            chk("m_done",    32'(if0.done),        32'(dn));
            chk("m_we",      32'(if0.writeenable), 32'(we));
            chk("m_illegal", 32'(if0.illegal),     32'(il));
            if (known) begin
                chk("m_rr1",   32'(if0.readreg1),  32'(m_f.rr1));
                chk("m_rr2",   32'(if0.readreg2),  32'(m_f.rr2));
                chk("m_wr",    32'(if0.writereg),  32'(m_f.wr));
                chk("m_aluop", 32'(if0.aluop),     32'(m_f.aluop));
                chk("m_imm",   32'(if0.immediate), 32'(m_f.imm));
                chk("m_isel",  32'(if0.imm_sel),   32'(m_f.isel));
                chk("m_nsel",  32'(if0.neg_sel),   32'(m_f.nsel));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_n(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Returns at the negedge of the DECODE period of the issued instruction.
    task automatic issue(input logic [31:0] ins);
        bit ok;
        ok = 0;
        @(negedge clk);
        if0.instruction = ins;
        if0.instr_valid = 1'b1;
        for (int n = 0; n < 30 && !ok; n++) begin
            if (if0.instr_ready === 1'b1) begin
                @(negedge clk);
                if0.instr_valid = 1'b0;
                ok = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            if0.instr_valid = 1'b0;
            $display("FAIL issue_timeout: got no acceptance expected acceptance of %08h", ins);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(if0.instr_ready), 32'd1);
        chk({tag, "_we"},    32'(if0.writeenable), 32'd0);
        chk({tag, "_done"},  32'(if0.done),        32'd0);
        chk({tag, "_ill"},   32'(if0.illegal),     32'd0);
        chk({tag, "_rr1"},   32'(if0.readreg1),    32'd0);
        chk({tag, "_rr2"},   32'(if0.readreg2),    32'd0);
        chk({tag, "_wr"},    32'(if0.writereg),    32'd0);
        chk({tag, "_alu"},   32'(if0.aluop),       32'd0);
        chk({tag, "_imm"},   32'(if0.immediate),   32'd0);
        chk({tag, "_isel"},  32'(if0.imm_sel),     32'd0);
        chk({tag, "_nsel"},  32'(if0.neg_sel),     32'd0);
    endtask

    initial begin
        int cnt_we;
        int cnt_done;
        int low;
        logic [7:0] op;

        if0.instr_valid = 1'b0;
        if0.instruction = '0;
        #1 rst_n = 1'b0;
        #1 check_reset_vals("reset");
        check_en = 1;
        wait_n(2);
        rst_n = 1'b1;

        // loadi r2 <- 95, WB in the 4th period after acceptance
        issue(32'h0002005F);
        chk("loadi_wr",   32'(if0.writereg),    32'd2);
        chk("loadi_isel", 32'(if0.imm_sel),     32'd1);
        chk("loadi_imm",  32'(if0.immediate),   32'd95);
        chk("loadi_rdy",  32'(if0.instr_ready), 32'd0);
        wait_n(2);
        chk("loadi_we_c3",   32'(if0.writeenable), 32'd0);
        wait_n(1);
        chk("loadi_we_c4",   32'(if0.writeenable), 32'd1);
        chk("loadi_done_c4", 32'(if0.done),        32'd1);
        wait_n(1);
        chk("loadi_we_c5",   32'(if0.writeenable), 32'd0);
        chk("loadi_rdy_c5",  32'(if0.instr_ready), 32'd1);

        // sub r1 <- r4 - r6
        issue(32'h03010406);
        chk("sub_rr1",  32'(if0.readreg1), 32'd4);
        chk("sub_rr2",  32'(if0.readreg2), 32'd6);
        chk("sub_wr",   32'(if0.writereg), 32'd1);
        chk("sub_alu",  32'(if0.aluop),    32'd1);
        chk("sub_nsel", 32'(if0.neg_sel),  32'd1);
        cnt_we = 0;
        for (int i = 0; i < 8; i++) begin
            cnt_we += int'(if0.writeenable);
            @(negedge clk);
        end
        chk("sub_we_pulses", 32'(cnt_we), 32'd1);

        // beq: done but never a write
        issue(32'h07000203);
        chk("beq_alu",  32'(if0.aluop),   32'd1);
        chk("beq_nsel", 32'(if0.neg_sel), 32'd1);
        cnt_we = 0;
        cnt_done = 0;
        for (int i = 0; i < 8; i++) begin
            cnt_we   += int'(if0.writeenable);
            cnt_done += int'(if0.done);
            @(negedge clk);
        end
        chk("beq_we_pulses",   32'(cnt_we),   32'd0);
        chk("beq_done_pulses", 32'(cnt_done), 32'd1);

        // undefined opcode
        issue(32'h09123456);
        chk("ill_pulse", 32'(if0.illegal),     32'd1);
        chk("ill_rdy",   32'(if0.instr_ready), 32'd0);
        wait_n(1);
        chk("ill_rdy_next",   32'(if0.instr_ready), 32'd1);
        chk("ill_pulse_next", 32'(if0.illegal),     32'd0);
        cnt_done = 0;
        cnt_we = 0;
        for (int i = 0; i < 5; i++) begin
            cnt_done += int'(if0.done);
            cnt_we   += int'(if0.writeenable);
            @(negedge clk);
        end
        chk("ill_no_done", 32'(cnt_done), 32'd0);
        chk("ill_no_we",   32'(cnt_we),   32'd0);

        // add aborted by reset mid-EXEC, then loadi r4 <- 15
        issue(32'h02030102);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rst_exec");
        wait_n(2);
        rst_n = 1'b1;
        issue(32'h0004000F);
        chk("loadi2_wr",  32'(if0.writereg),  32'd4);
        chk("loadi2_imm", 32'(if0.immediate), 32'd15);
        wait_n(3);
        chk("loadi2_we",   32'(if0.writeenable), 32'd1);
        chk("loadi2_done", 32'(if0.done),        32'd1);

        // mov aborted by reset right after entering WB
        issue(32'h01050300);
        wait_n(2);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_wb_we",   32'(if0.writeenable), 32'd0);
        chk("rst_wb_done", 32'(if0.done),        32'd0);
        wait_n(1);
        rst_n = 1'b1;

        // valid held across two back-to-back instructions
        @(negedge clk);
        if0.instruction = 32'h02010203;
        if0.instr_valid = 1'b1;
        @(negedge clk);
        if0.instruction = 32'h05020304;
        low = 0;
        for (int i = 0; i < 20 && if0.instr_ready !== 1'b1; i++) begin
            low++;
            @(negedge clk);
        end
        chk("b2b_ready_low", 32'(low), 32'(LAT + 2));
        @(negedge clk);
        if0.instr_valid = 1'b0;
        chk("b2b_second_rdy", 32'(if0.instr_ready), 32'd0);
        chk("b2b_second_alu", 32'(if0.aluop),       32'd3);
        wait_n(6);

        // randomized traffic with occasional asynchronous reset pulses
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            op = 8'($urandom_range(0, 9));
            if0.instr_valid = ($urandom_range(0, 3) != 0);
            if0.instruction = {op, 24'($urandom)};
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        if0.instr_valid = 1'b0;
        wait_n(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
